// File: rtl/riscv_pkg.sv
// Shared RISC-V pipeline definitions: NOP encoding, fetch FSM states
// and the default datapath width.
package riscv_pkg;

  localparam int XLEN_DEFAULT = 32;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    REQ  = 2'd0,
    WAIT = 2'd1,
    DROP = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry holding buffer for an instruction response that decode
// could not accept; clear wins over push, push wins over pop.
module fetch_skid_buf
  import riscv_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            i_push,
  input  logic            i_pop,
  input  logic            i_clear,
  input  logic [31:0]     i_instr,
  input  logic [XLEN-1:0] i_pc,
  output logic            o_valid,
  output logic [31:0]     o_instr,
  output logic [XLEN-1:0] o_pc
);

  logic            r_valid;
  logic [31:0]     r_instr;
  logic [XLEN-1:0] r_pc;

  always_ff @(posedge clk) begin
    if (reset || i_clear) begin
      r_valid <= 1'b0;
      r_instr <= NOP_INSTR;
      r_pc    <= '0;
    end else if (i_push) begin
      r_valid <= 1'b1;
      r_instr <= i_instr;
      r_pc    <= i_pc;
    end else if (i_pop) begin
      r_valid <= 1'b0;
    end
  end

  assign o_valid = r_valid;
  assign o_instr = r_instr;
  assign o_pc    = r_pc;

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC, single-outstanding imem handshake,
// holding buffer and IF/ID register. Optional FETCH_PERF_EN adds counters.
module fetch_unit
  import riscv_pkg::*;
#(
  parameter int              XLEN     = XLEN_DEFAULT,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stallF,
  input  logic            stallD,
  input  logic            flushD,
  input  logic            controlChange,
  input  logic [XLEN-1:0] pcTargetE,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ready,
  input  logic            imem_rvalid,
  input  logic [31:0]     imem_rdata,
`ifdef FETCH_PERF_EN
  output logic [31:0]     perfFetched,
  output logic [31:0]     perfDropped,
`endif
  output logic [31:0]     instrD,
  output logic [XLEN-1:0] pcD,
  output logic [XLEN-1:0] pcPlus4D,
  output logic            validD
);

  fetch_state_t    r_state;
  logic [XLEN-1:0] r_pcF;
  logic [XLEN-1:0] r_req_pc;

  logic            r_validD;
  logic [31:0]     r_instrD;
  logic [XLEN-1:0] r_pcD;
  logic [XLEN-1:0] r_pc4D;

  logic            w_buf_valid;
  logic [31:0]     w_buf_instr;
  logic [XLEN-1:0] w_buf_pc;

  logic w_req;
  logic w_hs;
  logic w_rsp;
  logic w_rsp_to_d;
  logic w_push;
  logic w_pop;
  logic w_drop;

  assign w_req = (r_state == REQ) && !stallF && !w_buf_valid
              && !controlChange && !reset;
  assign w_hs  = w_req && imem_ready;

  // A response is only kept when it is not overtaken by a redirect or reset
  assign w_rsp      = (r_state == WAIT) && imem_rvalid
                   && !controlChange && !reset;
  assign w_rsp_to_d = w_rsp && !stallD && !w_buf_valid;
  assign w_push     = w_rsp && !w_rsp_to_d;
  assign w_pop      = w_buf_valid && !stallD && !flushD;
  assign w_drop     = imem_rvalid && ((r_state == DROP)
                   || ((r_state == WAIT) && controlChange));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pcF <= RESET_PC;
      // Keep discarding if a response is still owed to an old request
      if ((r_state != REQ) && !imem_rvalid) r_state <= DROP;
      else                                  r_state <= REQ;
    end else begin
      if (controlChange) r_pcF <= pcTargetE;
      else if (w_hs)     r_pcF <= r_pcF + XLEN'(4);
      unique case (r_state)
        REQ:     if (w_hs) r_state <= WAIT;
        WAIT: begin
          if (imem_rvalid)        r_state <= REQ;
          else if (controlChange) r_state <= DROP;
        end
        DROP:    if (imem_rvalid) r_state <= REQ;
        default: r_state <= REQ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset)     r_req_pc <= RESET_PC;
    else if (w_hs) r_req_pc <= r_pcF;
  end

  fetch_skid_buf #(.XLEN(XLEN)) u_buf (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_clear (controlChange),
    .i_instr (imem_rdata),
    .i_pc    (r_req_pc),
    .o_valid (w_buf_valid),
    .o_instr (w_buf_instr),
    .o_pc    (w_buf_pc)
  );

  always_ff @(posedge clk) begin
    if (reset || flushD) begin
      r_validD <= 1'b0;
      r_instrD <= NOP_INSTR;
      r_pcD    <= '0;
      r_pc4D   <= XLEN'(4);
    end else if (!stallD) begin
      if (w_buf_valid) begin
        r_validD <= 1'b1;
        r_instrD <= w_buf_instr;
        r_pcD    <= w_buf_pc;
        r_pc4D   <= w_buf_pc + XLEN'(4);
      end else if (w_rsp_to_d) begin
        r_validD <= 1'b1;
        r_instrD <= imem_rdata;
        r_pcD    <= r_req_pc;
        r_pc4D   <= r_req_pc + XLEN'(4);
      end else begin
        r_validD <= 1'b0;
        r_instrD <= NOP_INSTR;
        r_pcD    <= '0;
        r_pc4D   <= XLEN'(4);
      end
    end
  end

`ifdef FETCH_PERF_EN
  logic [31:0] r_perf_fetched;
  logic [31:0] r_perf_dropped;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_perf_fetched <= '0;
      r_perf_dropped <= '0;
    end else begin
      if (w_rsp)  r_perf_fetched <= r_perf_fetched + 32'd1;
      if (w_drop) r_perf_dropped <= r_perf_dropped + 32'd1;
    end
  end

  assign perfFetched = r_perf_fetched;
  assign perfDropped = r_perf_dropped;
`else
  logic w_unused_drop;
  assign w_unused_drop = w_drop;
`endif

  assign imem_req  = w_req;
  assign imem_addr = r_pcF;
  assign instrD    = r_instrD;
  assign pcD       = r_pcD;
  assign pcPlus4D  = r_pc4D;
  assign validD    = r_validD;

endmodule
